// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit: stack pointer/occupancy engine with single and two-beat burst push/pop
module stack_pointer_unit #(
  parameter int ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] STACK_TOP = 32'h000F_FFFF,
  parameter int WORDS_PER_ENTRY = 2,
  parameter int DEPTH           = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stackOp,
  input  logic                  operation,
  input  logic                  burst,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] addressOut,
  output logic                  memEn,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WORDS_PER_ENTRY);
  typedef enum logic {IDLE, BEAT1} state_t;
  state_t state, state_nx;
  logic [OW-1:0] occ;
  logic [OW:0] ent;
  logic dir, beat1, req, legal, go, op_dir;
  always_comb begin
    beat1 = state == BEAT1;
    ent = burst ? (OW+1)'(2) : (OW+1)'(1);
    req = !beat1 && stackOp;
    // legality covers the whole operation so a burst is never issued partially
    legal = operation ? ({1'b0, occ} >= ent) : ({1'b0, occ} + ent <= (OW+1)'(DEPTH));
    op_dir = beat1 ? dir : operation;
    go = !rst && !stall && (beat1 || (req && legal));
    memEn = go;
    busy = beat1;
    addressOut = (beat1 || stackOp) && op_dir ? sp + STEP : sp;
    state_nx = req && legal && burst ? BEAT1 : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sp <= STACK_TOP;
      occ <= '0;
      dir <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (!stall) begin
      state <= state_nx;
      overflow <= req && !operation && !legal;
      underflow <= req && operation && !legal;
      if (req) dir <= operation;
      if (go) begin
        sp <= op_dir ? sp + STEP : sp - STEP;
        occ <= op_dir ? occ - 1'b1 : occ + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stack_pointer_unit.sv
// tb_stack_pointer_unit: directed vectors against default and DEPTH=3 instances
module tb_stack_pointer_unit;
  logic clk = 0, rst = 1, stack_op = 0, operation = 0, burst = 0, stall = 0;
  logic [31:0] addr, sp, addr3, sp3;
  logic mem_en, busy, ovf, unf, mem_en3, busy3, ovf3, unf3;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  stack_pointer_unit dut (.clk(clk), .rst(rst), .stackOp(stack_op), .operation(operation),
    .burst(burst), .stall(stall), .addressOut(addr), .memEn(mem_en), .busy(busy), .sp(sp),
    .overflow(ovf), .underflow(unf));
  stack_pointer_unit #(.DEPTH(3)) dut3 (.clk(clk), .rst(rst), .stackOp(stack_op),
    .operation(operation), .burst(burst), .stall(stall), .addressOut(addr3), .memEn(mem_en3),
    .busy(busy3), .sp(sp3), .overflow(ovf3), .underflow(unf3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, input logic o, input logic b);
    stack_op = s;
    operation = o;
    burst = b;
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    stall = 0;
    drive(0, 0, 0);
    step();
    rst = 0;
    #1;
  endtask
  initial begin
    do_reset();
    chk("rst_sp", sp, 32'hFFFFF);
    chk("rst_addr", addr, 32'hFFFFF);
    chk("rst_memen", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {ovf, unf}, 0);
    drive(1, 0, 0);
    chk("push_addr", addr, 32'hFFFFF);
    chk("push_memen", mem_en, 1);
    step(); drive(0, 0, 0);
    chk("push_sp", sp, 32'hFFFFD);
    chk("push_occ", dut.occ, 1);
    drive(1, 1, 0);
    chk("pop_addr", addr, 32'hFFFFF);
    chk("pop_memen", mem_en, 1);
    step(); drive(0, 0, 0);
    chk("pop_sp", sp, 32'hFFFFF);
    chk("pop_occ", dut.occ, 0);
    do_reset();
    drive(1, 0, 1);
    chk("bpush0_addr", addr, 32'hFFFFF);
    chk("bpush0_busy", busy, 0);
    step(); drive(0, 1, 0);
    chk("bpush1_addr", addr, 32'hFFFFD);
    chk("bpush1_busy", busy, 1);
    chk("bpush1_memen", mem_en, 1);
    step(); drive(0, 0, 0);
    chk("bpush_sp", sp, 32'hFFFFB);
    chk("bpush_occ", dut.occ, 2);
    chk("bpush_idle", busy, 0);
    drive(1, 1, 1);
    chk("bpop0_addr", addr, 32'hFFFFD);
    step(); drive(1, 0, 0);
    chk("bpop1_addr", addr, 32'hFFFFF);
    chk("bpop1_busy", busy, 1);
    step(); drive(0, 0, 0);
    chk("bpop_sp", sp, 32'hFFFFF);
    chk("bpop_occ", dut.occ, 0);
    do_reset();
    drive(1, 1, 0);
    chk("uf_memen", mem_en, 0);
    step(); drive(0, 0, 0);
    chk("uf_pulse", unf, 1);
    chk("uf_sp", sp, 32'hFFFFF);
    step();
    chk("uf_clear", unf, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      chk("d3_push_memen", mem_en3, 1);
      step();
    end
    chk("d3_full_memen", mem_en3, 0);
    step(); drive(0, 0, 0);
    chk("d3_ovf", ovf3, 1);
    chk("d3_ovf_sp", sp3, 32'hFFFF9);
    step();
    chk("d3_ovf_clear", ovf3, 0);
    drive(1, 1, 0);
    step(); drive(1, 0, 1);
    chk("d3_pop_sp", sp3, 32'hFFFFB);
    chk("d3_burst_memen", mem_en3, 0);
    step(); drive(0, 0, 0);
    chk("d3_burst_ovf", ovf3, 1);
    chk("d3_burst_busy", busy3, 0);
    chk("d3_burst_sp", sp3, 32'hFFFFB);
    chk("d3_burst_occ", dut3.occ, 2);
    do_reset();
    drive(1, 0, 1);
    step(); drive(0, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_busy", busy, 1);
      chk("stall_memen", mem_en, 0);
      chk("stall_sp", sp, 32'hFFFFD);
      step();
    end
    stall = 0;
    #1;
    chk("unstall_addr", addr, 32'hFFFFD);
    chk("unstall_memen", mem_en, 1);
    step();
    chk("unstall_idle", busy, 0);
    chk("unstall_sp", sp, 32'hFFFFB);
    do_reset();
    drive(1, 0, 1);
    step(); drive(0, 0, 0);
    rst = 1;
    #1;
    chk("midrst_memen", mem_en, 0);
    step();
    rst = 0;
    #1;
    chk("midrst_sp", sp, 32'hFFFFF);
    chk("midrst_occ", dut.occ, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_memen2", mem_en, 0);
    step();
    chk("midrst_sp2", sp, 32'hFFFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
